seg_scan: RTL and testbench
===========================

Name: seg_scan

Overview:
Time-multiplexed scan controller for the 8-digit common-anode seven-segment display on the board.
- Sits directly upstream of the hex-to-segment pattern decoder. It drives that decoder's 4-bit code input and drives the digit anodes.
- Double-buffers the displayed word so the next frame never shows mixed old/new digits.
- Provides per-digit blanking and optional leading-zero suppression.

Parameters:
NDIGITS, 8, number of digits scanned; legal range 1..8; data width is 4*NDIGITS.
SCAN_DIV, 100000, clk cycles each digit is lit; legal values are >=2.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
en  in  1  scan enable; 0 turns the display off and holds the scan position.
load  in  1  one-cycle strobe; captures data into the pending buffer.
data  in  4*NDIGITS  hex word; nibble i is shown on digit i, with digit 0 rightmost.
blank_mask  in  NDIGITS  bit i = 1 forces digit i off.
lz_en  in  1  1 enables leading-zero suppression.
code  out  4  nibble for the currently lit digit; feeds the pattern decoder.
an  out  NDIGITS  active-low anode selects; at most one bit is 0 at any time.
digit_idx  out  3  index of the currently selected digit.
frame_done  out  1  one-cycle pulse when the scan wraps from digit NDIGITS-1 to digit 0.

Behaviour:
- Reset (rst_n=0 at a clock edge) clears the following; reset mid-scan aborts the frame immediately.
  - Outputs: code=0, an=all 1s, digit_idx=0, frame_done=0.
  - Internal state: prescaler=0, pending=0, shadow=0, pending_valid=0.
- Prescaler (width clog2(SCAN_DIV)):
  - When en=1, counts 0..SCAN_DIV-1 and then wraps to 0.
  - tick is asserted internally only in the cycle where the prescaler equals SCAN_DIV-1.
  - When en=0, the prescaler is forced to 0.
- Digit index: on tick, idx <= (idx==NDIGITS-1) ? 0 : idx+1. When en=0, idx is held at 0.
- Buffering (two registers, pending and shadow):
  - load=1 captures data into pending and sets pending_valid. A later load in the same frame overwrites pending, so the last load wins.
  - Pending is copied into shadow when pending_valid=1 and either (a) en=0 or (b) a tick wraps idx to 0. The copy clears pending_valid.
  - If load coincides with a wrap tick, the newly loaded data is the value copied into shadow.
  - Shadow is never written in the middle of a frame.
- Leading-zero suppression: digit i (i>0) is suppressed when lz_en=1 and shadow nibbles NDIGITS-1 down to i are all 0. Digit 0 is never suppressed.
- Registered outputs, updated every cycle from the current idx and shadow:
  - digit_idx <= idx; code <= shadow[4*idx +: 4].
  - an <= all 1s if en=0, blank_mask[idx]=1, or digit idx is suppressed; otherwise an <= ~(1<<idx).
  - frame_done <= tick && idx==NDIGITS-1.
- Latency: outputs reflect an idx change 1 cycle after the tick edge. code and an always change in the same cycle, so the anode never shows a stale nibble.
- en falling edge: one cycle later an = all 1s, and the scan restarts at digit 0 when en returns to 1.
- NDIGITS=1: idx stays at 0, and frame_done pulses on every tick.

Test Plan (SCAN_DIV=4, NDIGITS=8):
1. Reset, then en=1, load data=32'h1234_5678 while en=0 before enabling. Required: an sequence FE,FD,FB,F7,EF,DF,BF,7F with code 8,7,6,5,4,3,2,1; each digit held 4 cycles; frame_done pulses once per 32 cycles.
2. Scanning 32'h1234_5678, pulse load with 32'hAAAA_AAAA while digit 3 is lit. Required: digits 4..7 still show 4,3,2,1; the next frame shows A on all digits.
3. lz_en=1 with data=32'h0000_00F0. Required: only digits 0 and 1 are lit, showing 0 and F; an = FF during digits 2..7. Repeat with data=0: only digit 0 is lit, showing 0.
4. blank_mask=8'h0F with data=32'h8765_4321. Required: an = FF during digits 0..3; digits 4..7 show 5,6,7,8.
5. Drop en at digit 5, then assert rst_n=0 mid-frame. Required: an = FF the next cycle; digit_idx=0; after re-enable, the scan restarts at digit 0 and shows the pending value.
6. load coincident with the wrap tick, data=32'hDEAD_BEEF. Required: the new frame's digit 0 shows F.

Source files
------------

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed scan controller for a common-anode seven-segment
// display. It double-buffers the displayed word and supports per-digit blanking
// and leading-zero suppression. All outputs are registered.
module seg_scan #(
  parameter int NDIGITS  = 8,
  parameter int SCAN_DIV = 100000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   data,
  input  logic [NDIGITS-1:0]     blank_mask,
  input  logic                   lz_en,
  output logic [3:0]             code,
  output logic [NDIGITS-1:0]     an,
  output logic [2:0]             digit_idx,
  output logic                   frame_done
);

  localparam int             PW       = $clog2(SCAN_DIV);
  localparam int             DW       = 4 * NDIGITS;
  localparam logic [PW-1:0]  PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [2:0]     IDX_LAST = 3'(NDIGITS - 1);

  logic [PW-1:0]      presc;
  logic [2:0]         idx;
  logic [DW-1:0]      pending;
  logic [DW-1:0]      shadow;
  logic               pending_valid;

  logic               tick;
  logic               wrap;
  logic [DW-1:0]      pend_src;
  logic               pend_src_valid;
  logic               copy;

  logic [NDIGITS-1:0] sup;
  logic [NDIGITS-1:0] sel;
  logic [3:0]         cur_code;
  logic               cur_blank;
  logic               cur_sup;
  logic               all_zero;
  logic               lit;

  assign tick = en && (presc == PRE_LAST);
  assign wrap = tick && (idx == IDX_LAST);

  // A load arriving on the same edge as the frame boundary must be the value
  // that lands in shadow, so the copy source bypasses the pending register.
  assign pend_src       = load ? data : pending;
  assign pend_src_valid = load || pending_valid;
  assign copy           = pend_src_valid && (!en || wrap);

  // Per-digit leading-zero flags and selection of the currently scanned digit.
  always_comb begin
    sup       = '0;
    sel       = '0;
    cur_code  = 4'h0;
    cur_blank = 1'b0;
    cur_sup   = 1'b0;
    all_zero  = 1'b1;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (shadow[4*i +: 4] == 4'h0);
      sup[i]   = lz_en && all_zero && (i != 0);
      if (idx == 3'(i)) begin
        sel[i]    = 1'b1;
        cur_code  = shadow[4*i +: 4];
        cur_blank = blank_mask[i];
        cur_sup   = sup[i];
      end
    end
  end

  assign lit = en && !cur_blank && !cur_sup;

  // Prescaler and digit index; disabling parks the scan at digit 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= 3'd0;
    end else if (!en) begin
      presc <= '0;
      idx   <= 3'd0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick)
        idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
    end
  end

  // Pending/shadow double buffer; shadow only changes at a frame boundary or while disabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending       <= '0;
      shadow        <= '0;
      pending_valid <= 1'b0;
    end else begin
      if (load)
        pending <= data;
      if (copy) begin
        shadow        <= pend_src;
        pending_valid <= 1'b0;
      end else if (load) begin
        pending_valid <= 1'b1;
      end
    end
  end

  // Registered display outputs; code and an move together on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code       <= 4'h0;
      an         <= '1;
      digit_idx  <= 3'd0;
      frame_done <= 1'b0;
    end else begin
      code       <= cur_code;
      an         <= lit ? ~sel : '1;
      digit_idx  <= idx;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: a driver applies directed and random stimulus
// and pushes the expected next-cycle outputs; a monitor pops and compares.
module tb_seg_scan;

  localparam int ND = 8;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [31:0] data = '0;
  logic [7:0]  blank_mask = '0;
  logic        lz_en = 1'b0;
  logic [3:0]  code;
  logic [7:0]  an;
  logic [2:0]  digit_idx;
  logic        frame_done;

  seg_scan #(.NDIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .data       (data),
    .blank_mask (blank_mask),
    .lz_en      (lz_en),
    .code       (code),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] code;
    logic [7:0] an;
    logic [2:0] di;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errors  = 0;

  // Reference model: cnt is the number of enabled edges since the scan last
  // restarted; the lit digit and the tick follow from plain division.
  int          cnt   = 0;
  logic [31:0] shown = '0;
  logic [31:0] pend  = '0;
  bit          pv    = 0;

  bit          g_en    = 0;
  logic [31:0] g_data  = '0;
  logic [7:0]  g_blank = '0;
  bit          g_lz    = 0;

  task automatic step(input bit r, input bit e, input bit l, input logic [31:0] d,
                      input logic [7:0] b, input bit lz);
    exp_t x;
    int   ci;
    bit   tk, wr, lit;
    @(negedge clk);
    rst_n = r; en = e; load = l; data = d; blank_mask = b; lz_en = lz;
    if (!r) begin
      x = '{code: 4'h0, an: 8'hFF, di: 3'd0, fd: 1'b0};
      cnt = 0; shown = '0; pend = '0; pv = 0;
    end else begin
      ci  = (cnt / SD) % ND;
      tk  = e && (cnt % SD == SD - 1);
      wr  = tk && (ci == ND - 1);
      lit = e && !b[ci] && !(lz && ci > 0 && (shown >> (4 * ci)) == 0);
      x.code = 4'((shown >> (4 * ci)) & 32'hF);
      x.an   = lit ? ~(8'h01 << ci) : 8'hFF;
      x.di   = 3'(ci);
      x.fd   = wr;
      if (l) begin pend = d; pv = 1; end
      if (pv && (!e || wr)) begin shown = pend; pv = 0; end
      cnt = e ? (cnt + 1) % (SD * ND) : 0;
    end
    q.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1, g_en, 0, g_data, g_blank, g_lz);
  endtask

  task automatic ld(input logic [31:0] d);
    g_data = d;
    step(1, g_en, 1, d, g_blank, g_lz);
  endtask

  // Monitor: compare every presented output against the oldest expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        vectors++;
        if (code !== x.code || an !== x.an || digit_idx !== x.di || frame_done !== x.fd) begin
          errors++;
          $display("FAIL scan_out t=%0t: got code=%h an=%h idx=%0d fd=%b, want code=%h an=%h idx=%0d fd=%b",
                   $time, code, an, digit_idx, frame_done, x.code, x.an, x.di, x.fd);
        end
      end
    end
  end

  initial begin
    logic [31:0] d;
    int          k;
    // reset, then preload while disabled
    repeat (3) step(0, 0, 0, '0, '0, 0);
    g_en = 0; ld(32'h1234_5678);
    g_en = 1; idle(80);
    // mid-frame load must wait for the frame boundary
    ld(32'hAAAA_AAAA);
    idle(70);
    // leading-zero suppression
    g_lz = 1; g_en = 0; ld(32'h0000_00F0);
    g_en = 1; idle(40);
    g_en = 0; ld(32'h0);
    g_en = 1; idle(40);
    g_lz = 0;
    // blanking of the low four digits
    g_blank = 8'h0F; g_en = 0; ld(32'h8765_4321);
    g_en = 1; idle(40);
    g_blank = 8'h00;
    // disable and reset mid-frame, then restart with a pending value
    g_en = 0; idle(1);
    g_en = 1; idle(20);
    ld(32'h5555_1111);
    g_en = 0; idle(2);
    step(0, 0, 0, g_data, g_blank, g_lz);
    idle(2);
    ld(32'hCAFE_F00D);
    g_en = 1; idle(40);
    // load on the wrap tick
    ld(32'h1111_2222);
    g_en = 0; idle(1);
    g_en = 1; idle(31);
    ld(32'hDEAD_BEEF);
    idle(10);
    // randomized phase
    for (int c = 0; c < 4000; c++) begin
      if (g_en ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 3) == 0)) g_en = !g_en;
      if ($urandom_range(0, 299) == 0) g_blank = 8'($urandom);
      if ($urandom_range(0, 149) == 0) g_lz = !g_lz;
      if ($urandom_range(0, 999) == 0) begin
        step(0, g_en, 0, g_data, g_blank, g_lz);
      end else if ($urandom_range(0, 23) == 0) begin
        d = $urandom;
        k = $urandom_range(0, 8);
        if (k > 0) d = d & (32'hFFFF_FFFF >> (4 * k));
        ld(d);
      end else begin
        idle(1);
      end
    end
    g_en = 1; idle(2);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
